// File: rtl/dup_keyed_burst_ctrl.sv
// Key-locked burst/handshake controller: each key bit picks a genuine or decoy state copy at one branch.
// Optional decoy lockout is compiled in when DUP_LOCKOUT_EN is defined.
module dup_keyed_burst_ctrl #(
   parameter logic [3:0] CORRECT_KEY = 4'b1011,
   parameter int         CNT_W       = 4,
   parameter int         BURST_LEN   = 8,
   parameter int         TO_W        = 5,
   parameter int         ACK_TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic             en_i,
   input  logic             ack_i,
   input  logic             abort_i,
   input  logic [3:0]       key_i,
   output logic             busy_o,
   output logic             beat_o,
   output logic             req_o,
   output logic             done_o,
   output logic             err_o,
   output logic [CNT_W-1:0] cnt_o
);

   typedef enum logic [3:0] {
      S_IDLE       = 4'd0,
      S_LOAD       = 4'd1,
      S_LOAD_D     = 4'd2,
      S_RUN        = 4'd3,
      S_RUN_D      = 4'd4,
      S_WAIT_ACK   = 4'd5,
      S_WAIT_ACK_D = 4'd6,
      S_DONE       = 4'd7,
      S_DONE_D     = 4'd8,
      S_FAULT      = 4'd9,
      S_LOCKED     = 4'd10
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] RUN_LIM   = CNT_W'(BURST_LEN - 1);
   localparam logic [CNT_W-1:0] RUN_D_LIM = CNT_W'(BURST_LEN - 2);
   localparam logic [TO_W-1:0]  TO_ZERO   = {TO_W{1'b0}};
   localparam logic [TO_W-1:0]  TO_ONE    = TO_W'(1);
   localparam logic [TO_W-1:0]  TO_LIM    = TO_W'(ACK_TIMEOUT - 1);

   state_t           state_q, state_d, state_nom_s;
   logic [CNT_W-1:0] cnt_q, cnt_d, run_lim_s;
   logic [TO_W-1:0]  tcnt_q, tcnt_d;
   logic [3:0]       key_ok_s;
   logic             abort_ok_s;
   logic             busy_q, run_q, req_q, done_q, err_q;

   assign key_ok_s   = ~(key_i ^ CORRECT_KEY);
   // The decoy run copy ends one beat early.
   assign run_lim_s  = (state_q == S_RUN_D) ? RUN_D_LIM : RUN_LIM;
   assign abort_ok_s = abort_i && (state_q != S_IDLE) && (state_q != S_LOCKED);

   // Nominal next state and counter updates; abort has top priority
   always_comb begin
      state_nom_s = state_q;
      cnt_d       = cnt_q;
      tcnt_d      = tcnt_q;
      if (abort_ok_s) begin
         state_nom_s = S_IDLE;
         cnt_d       = CNT_ZERO;
         tcnt_d      = TO_ZERO;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  state_nom_s = key_ok_s[0] ? S_LOAD : S_LOAD_D;
               end else begin
                  state_nom_s = S_IDLE;
               end
            end
            S_LOAD, S_LOAD_D: begin
               cnt_d       = CNT_ZERO;
               state_nom_s = key_ok_s[1] ? S_RUN : S_RUN_D;
            end
            S_RUN, S_RUN_D: begin
               if (en_i && (cnt_q == run_lim_s)) begin
                  cnt_d       = CNT_ZERO;
                  tcnt_d      = TO_ZERO;
                  state_nom_s = key_ok_s[2] ? S_WAIT_ACK : S_WAIT_ACK_D;
               end else if (en_i) begin
                  cnt_d = cnt_q + CNT_ONE;
               end else begin
                  cnt_d = cnt_q;
               end
            end
            S_WAIT_ACK: begin
               if (ack_i) begin
                  state_nom_s = key_ok_s[3] ? S_DONE : S_DONE_D;
               end else if (tcnt_q == TO_LIM) begin
                  state_nom_s = S_FAULT;
               end else begin
                  tcnt_d = tcnt_q + TO_ONE;
               end
            end
            S_WAIT_ACK_D: begin
               if (tcnt_q == TO_LIM) begin
                  state_nom_s = S_FAULT;
               end else begin
                  tcnt_d = tcnt_q + TO_ONE;
               end
            end
            S_DONE, S_DONE_D: begin
               state_nom_s = S_IDLE;
            end
            S_FAULT: begin
               state_nom_s = S_FAULT;
            end
`ifdef DUP_LOCKOUT_EN
            S_LOCKED: begin
               state_nom_s = S_LOCKED;
            end
`endif
            default: begin
               state_nom_s = S_IDLE;
               cnt_d       = CNT_ZERO;
               tcnt_d      = TO_ZERO;
            end
         endcase
      end
   end

`ifdef DUP_LOCKOUT_EN
   logic [1:0] dcnt_q, dcnt_d;
   logic       dup_entry_s;

   function automatic logic is_dup(input state_t s);
      case (s)
         S_LOAD_D, S_RUN_D, S_WAIT_ACK_D, S_DONE_D: is_dup = 1'b1;
         default:                                   is_dup = 1'b0;
      endcase
   endfunction

   assign dup_entry_s = is_dup(state_nom_s) && (state_nom_s != state_q);

   // Decoy entry accounting; the entry that would reach three diverts into LOCKED
   always_comb begin
      if (dup_entry_s && (dcnt_q >= 2'd2)) begin
         state_d = S_LOCKED;
         dcnt_d  = dcnt_q;
      end else if (dup_entry_s) begin
         state_d = state_nom_s;
         dcnt_d  = dcnt_q + 2'd1;
      end else begin
         state_d = state_nom_s;
         dcnt_d  = dcnt_q;
      end
   end
`else
   assign state_d = state_nom_s;
`endif

   // State, counters and Moore outputs decoded from the next state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= CNT_ZERO;
         tcnt_q  <= TO_ZERO;
         busy_q  <= 1'b0;
         run_q   <= 1'b0;
         req_q   <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
`ifdef DUP_LOCKOUT_EN
         dcnt_q  <= 2'd0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tcnt_q  <= tcnt_d;
         busy_q  <= (state_d != S_IDLE) && (state_d != S_LOCKED);
         run_q   <= (state_d == S_RUN) || (state_d == S_RUN_D);
         req_q   <= (state_d == S_WAIT_ACK) || (state_d == S_WAIT_ACK_D);
         done_q  <= (state_d == S_DONE);
         err_q   <= (state_d == S_DONE_D) || (state_d == S_FAULT) || (state_d == S_LOCKED);
`ifdef DUP_LOCKOUT_EN
         dcnt_q  <= dcnt_d;
`endif
      end
   end

   assign busy_o = busy_q;
   assign beat_o = run_q & en_i;
   assign req_o  = req_q;
   assign done_o = done_q;
   assign err_o  = err_q;
   assign cnt_o  = cnt_q;

endmodule
